// File: rtl/fifo_rd_arbiter_pkg.sv
// afifo_pkg: shared pointer type and gray/binary conversion helpers for the async FIFO.
//  Helpers work on a 32-bit container; callers zero-extend their pointer and truncate the result,
//  which is exact because leading zeros do not disturb either conversion.
package afifo_pkg;
    localparam int DEF_ADDRSIZE = 9;
    localparam int CW = 32;
    typedef logic [DEF_ADDRSIZE:0] ptr_t;
    function automatic logic [CW-1:0] bin2gray(input logic [CW-1:0] b);
        return b ^ (b >> 1);
    endfunction
    // Each binary bit is the XOR of its gray bit and every gray bit above it.
    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        b = g;
        for (int i = 1; i < CW; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: consumer-side bus of the FIFO read arbiter.
//  req        per-consumer read request
//  gnt        one-hot grant, valid together with dout_valid
//  dout       popped word
//  dout_valid dout/dout_id/gnt valid this cycle
//  dout_id    index of the consumer owning dout
//  master: consumer side, slave: arbiter side.
interface fifo_rd_arbiter_if #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
);
    localparam int IDW = $clog2(NREQ);
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     gnt;
    logic [DATASIZE-1:0] dout;
    logic                dout_valid;
    logic [IDW-1:0]      dout_id;
    modport master (output req, input gnt, dout, dout_valid, dout_id);
    modport slave  (input req, output gnt, dout, dout_valid, dout_id);
endinterface

// File: rtl/fifo_rd_arbiter_rr.sv
// rr_arbiter: round-robin selection of one requester per cycle; owns the priority pointer.
//  rclk/r_rst_n  clock, synchronous active-low reset
//  req           per-consumer requests
//  en            arbitration enabled (FIFO not empty)
//  winner        combinational index of the selected requester
//  valid         a requester is selected and a pop happens this cycle
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    rclk,
    input  logic                    r_rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    valid
);
    localparam int IW = $clog2(NREQ);
    logic [IW-1:0] ptr;
    logic [IW:0]   k;
    assign valid = en & |req;
    // Scan from the farthest candidate back to ptr so the nearest requester is the last assignment.
    always_comb begin
        winner = ptr;
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = {1'b0, ptr} + (IW + 1)'(i);
            k = (k >= (IW + 1)'(NREQ)) ? k - (IW + 1)'(NREQ) : k;
            winner = req[k[IW-1:0]] ? k[IW-1:0] : winner;
        end
    end
    always_ff @(posedge rclk) begin
        if (!r_rst_n) ptr <= '0;
        else if (valid) ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: read-side controller of the async FIFO, shares the read port among NREQ consumers.
//  rclk/r_rst_n  read clock, synchronous active-low reset
//  wptr_sync     synchronised gray write pointer
//  rdata_mem     RAM read data (combinational from raddr)
//  raddr         RAM read address
//  rinc          pop strobe
//  rptr          registered gray read pointer, to the r2w synchronizer
//  rempty        registered empty flag
//  rlevel        registered occupancy
//  cons          consumer bus (req in; gnt/dout/dout_valid/dout_id out, one cycle after the pop)
module fifo_rd_arbiter
    import afifo_pkg::*;
#(
    parameter int ADDRSIZE = 9,
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
) (
    input  logic                rclk,
    input  logic                r_rst_n,
    input  logic [ADDRSIZE:0]   wptr_sync,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rinc,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    fifo_rd_arbiter_if.slave    cons
);
    localparam int PW  = ADDRSIZE + 1;
    localparam int IDW = $clog2(NREQ);
    logic [ADDRSIZE:0] rbin, rbin_next, rgray_next;
    logic [IDW-1:0]    winner;
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .rclk    (rclk),
        .r_rst_n (r_rst_n),
        .req     (cons.req),
        .en      (!rempty),
        .winner  (winner),
        .valid   (rinc)
    );
    assign raddr      = rbin[ADDRSIZE-1:0];
    assign rbin_next  = rbin + PW'(rinc);
    assign rgray_next = PW'(bin2gray(CW'(rbin_next)));
    // Empty compares against the post-pop pointer so a same-cycle pop and write are both counted.
    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            rbin            <= '0;
            rptr            <= '0;
            rempty          <= 1'b1;
            rlevel          <= '0;
            cons.gnt        <= '0;
            cons.dout       <= '0;
            cons.dout_valid <= 1'b0;
            cons.dout_id    <= '0;
        end else begin
            rbin            <= rbin_next;
            rptr            <= rgray_next;
            rempty          <= rgray_next == wptr_sync;
            rlevel          <= PW'(gray2bin(CW'(wptr_sync))) - rbin_next;
            cons.gnt        <= rinc ? NREQ'(1) << winner : '0;
            cons.dout       <= rinc ? rdata_mem : cons.dout;
            cons.dout_valid <= rinc;
            cons.dout_id    <= rinc ? winner : cons.dout_id;
        end
    end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: randomized scoreboard bench for fifo_rd_arbiter against a queue-based FIFO model.
module tb_fifo_rd_arbiter;
    localparam int AW = 3;
    localparam int PW = AW + 1;
    localparam int DW = 8;
    localparam int N = 4;
    localparam int DEPTH = 1 << AW;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    id;
    } item_t;
    logic          rclk = 1'b0;
    logic          r_rst_n;
    logic [PW-1:0] wptr_sync, rptr, rlevel;
    logic [DW-1:0] rdata_mem;
    logic [AW-1:0] raddr;
    logic          rinc, rempty;
    logic [DW-1:0] mem [DEPTH];
    fifo_rd_arbiter_if #(.DATASIZE(DW), .NREQ(N)) cons ();
    fifo_rd_arbiter #(.ADDRSIZE(AW), .DATASIZE(DW), .NREQ(N)) dut (
        .rclk      (rclk),
        .r_rst_n   (r_rst_n),
        .wptr_sync (wptr_sync),
        .rdata_mem (rdata_mem),
        .raddr     (raddr),
        .rinc      (rinc),
        .rptr      (rptr),
        .rempty    (rempty),
        .rlevel    (rlevel),
        .cons      (cons)
    );
    always #5 rclk = ~rclk;
    assign rdata_mem = mem[raddr];
    item_t         q[$];
    item_t         pitem;
    logic [DW-1:0] wq[$];
    int  total = 0, bad = 0;
    bit  started = 0, pend = 0;
    bit  c_empty = 1, c_pop = 0, n_empty = 1;
    int  c_level = 0, n_level = 0, c_rptr = 0, c_raddr = 0;
    int  rd = 0, wb = 0, ptr = 0;
    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Monitor: compares the registered view against the model, popping one scoreboard entry per delivered word.
    always @(negedge rclk) begin
        item_t it;
        if (started) begin
            chk("rempty", int'(rempty), int'(c_empty));
            chk("rlevel", int'(rlevel), c_level);
            chk("rptr", int'(rptr), c_rptr);
            chk("rinc", int'(rinc), int'(c_pop));
            chk("raddr", int'(raddr), c_raddr);
            chk("dout_valid", int'(cons.dout_valid), int'(q.size() != 0));
            if (q.size() != 0) begin
                it = q.pop_front();
                chk("dout", int'(cons.dout), int'(it.d));
                chk("dout_id", int'(cons.dout_id), int'(it.id));
                chk("gnt", int'(cons.gnt), 1 << it.id);
            end else begin
                chk("gnt_idle", int'(cons.gnt), 0);
            end
        end
    end
    // Driver plus reference model: a FIFO of written words, a pop count and a round-robin start index.
    initial begin
        int mode, wrate, w;
        logic [DW-1:0] d;
        r_rst_n = 1'b0;
        cons.req = '1;
        wptr_sync = 4'b0110;
        foreach (mem[i]) mem[i] = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge rclk);
            #1;
            started = 1;
            if (!r_rst_n) begin
                q.delete();
                wq.delete();
                rd = 0;
                wb = 0;
                ptr = 0;
                c_empty = 1;
                c_level = 0;
            end else begin
                if (pend) q.push_back(pitem);
                c_empty = n_empty;
                c_level = n_level;
            end
            pend = 0;
            c_rptr = gray(rd);
            mode = (cyc / 150) % 4;
            wrate = 30 + 35 * ((cyc / 50) % 3);
            r_rst_n = !(cyc < 2 || $urandom_range(249) == 0);
            cons.req = cyc < 2 ? 4'hF : mode == 0 ? 4'($urandom) : mode == 1 ? 4'hF : mode == 2 ? 4'b1010 : 4'b0100;
            if (r_rst_n && wq.size() < DEPTH && $urandom_range(99) < wrate) begin
                d = DW'($urandom);
                mem[wb % DEPTH] = d;
                wq.push_back(d);
                wb = (wb + 1) % (2 * DEPTH);
            end
            wptr_sync = cyc < 2 ? 4'b0110 : r_rst_n ? PW'(gray(wb)) : PW'($urandom);
            c_raddr = rd % DEPTH;
            c_pop = !c_empty && cons.req != 0;
            if (c_pop) begin
                w = -1;
                for (int i = 0; i < N; i++) if (w < 0 && cons.req[(ptr + i) % N]) w = (ptr + i) % N;
                pitem.d = wq.pop_front();
                pitem.id = 2'(w);
                pend = 1;
                rd = (rd + 1) % (2 * DEPTH);
                ptr = (w + 1) % N;
            end
            n_empty = wq.size() == 0;
            n_level = wq.size();
        end
        @(posedge rclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
